// File: rtl/airlock_pkg.sv
// Shared types and defaults for the bathysphere airlock sequencer.
// Pure declarations; no logic, no latency, no flow control.
// Used by the controller.
package airlock_pkg;

    typedef enum logic [2:0] {
        DRY_IDLE,
        WET_IDLE,
        FILL,
        DRAIN,
        INNER_OPEN,
        OUTER_OPEN
    } state_t;

    localparam logic DIR_ARRIVE = 1'b0;
    localparam logic DIR_DEPART = 1'b1;

    localparam int DEF_FILL_CYCLES  = 8;
    localparam int DEF_DRAIN_CYCLES = 8;
    localparam int DEF_DOOR_TIMEOUT = 64;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/airlock_timer.sv
// Loadable down-counter that parks at zero; load wins over count.
// Latency: value updates one cycle after load/en; zero is combinational.
// No backpressure: counts whenever en is high and value is nonzero.
module airlock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         zero
);

    assign zero = (value == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && !zero) begin
            value <= value - 1'b1;
        end
    end

endmodule

// File: rtl/airlock_controller.sv
// Airlock sequencer: one arrival/departure at a time, pumps before doors, doors never both open.
// Latency: request accepted the cycle it is seen in an idle state; ack one cycle after final transit_done.
// Requests are level-held; ignored while busy (or faulted). Optional door watchdog: AIRLOCK_WATCHDOG_EN.
module airlock_controller
    import airlock_pkg::*;
#(
    parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int DOOR_TIMEOUT = DEF_DOOR_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic arrive_req,
    input  logic depart_req,
    input  logic transit_done,
    output logic inner_door_open,
    output logic outer_door_open,
    output logic pump_fill,
    output logic pump_drain,
    output logic arrive_ack,
    output logic depart_ack,
    output logic busy,
    output logic chamber_wet,
    output logic fault
);

    localparam int TW = $clog2(max3(FILL_CYCLES, DRAIN_CYCLES, DOOR_TIMEOUT) + 1);

    state_t        state, state_n;
    logic          dir, dir_n;
    logic          arrive_ack_n, depart_ack_n;
    logic          fault_q;
    logic          req_ok;
    logic          door_timeout;
    logic          tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0] tmr_load_val, tmr_value;

    airlock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

`ifdef AIRLOCK_WATCHDOG_EN
    assign tmr_en       = (state == FILL) || (state == DRAIN) ||
                          (state == INNER_OPEN) || (state == OUTER_OPEN);
    assign door_timeout = tmr_zero;

    // Sticky until reset; only a door state that expires without transit trips it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if ((state == INNER_OPEN || state == OUTER_OPEN) && !transit_done && door_timeout) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign tmr_en       = (state == FILL) || (state == DRAIN);
    assign door_timeout = 1'b0;
    assign fault_q      = 1'b0;
`endif

    assign req_ok = !fault_q;
    assign fault  = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= DRY_IDLE;
            dir        <= DIR_ARRIVE;
            arrive_ack <= 1'b0;
            depart_ack <= 1'b0;
        end else begin
            state      <= state_n;
            dir        <= dir_n;
            arrive_ack <= arrive_ack_n;
            depart_ack <= depart_ack_n;
        end
    end

    always_comb begin
        state_n      = state;
        dir_n        = dir;
        arrive_ack_n = 1'b0;
        depart_ack_n = 1'b0;
        case (state)
            // Prefer the request that needs no pumping from the current chamber state.
            DRY_IDLE: begin
                if (req_ok && depart_req) begin
                    state_n = INNER_OPEN;
                    dir_n   = DIR_DEPART;
                end else if (req_ok && arrive_req) begin
                    state_n = FILL;
                    dir_n   = DIR_ARRIVE;
                end
            end
            WET_IDLE: begin
                if (req_ok && arrive_req) begin
                    state_n = OUTER_OPEN;
                    dir_n   = DIR_ARRIVE;
                end else if (req_ok && depart_req) begin
                    state_n = DRAIN;
                    dir_n   = DIR_DEPART;
                end
            end
            FILL: begin
                if (tmr_zero) state_n = OUTER_OPEN;
            end
            DRAIN: begin
                if (tmr_zero) state_n = INNER_OPEN;
            end
            OUTER_OPEN: begin
                if (transit_done) begin
                    if (dir == DIR_ARRIVE) begin
                        state_n = DRAIN;
                    end else begin
                        state_n      = WET_IDLE;
                        depart_ack_n = 1'b1;
                    end
                end else if (door_timeout) begin
                    state_n = WET_IDLE;
                end
            end
            INNER_OPEN: begin
                if (transit_done) begin
                    if (dir == DIR_ARRIVE) begin
                        state_n      = DRY_IDLE;
                        arrive_ack_n = 1'b1;
                    end else begin
                        state_n = FILL;
                    end
                end else if (door_timeout) begin
                    state_n = DRY_IDLE;
                end
            end
            default: state_n = DRY_IDLE;
        endcase
    end

    // Timer is reloaded on every state change, so it never needs to wrap.
    always_comb begin
        tmr_load = (state_n != state);
        case (state_n)
            FILL:    tmr_load_val = TW'(FILL_CYCLES - 1);
            DRAIN:   tmr_load_val = TW'(DRAIN_CYCLES - 1);
            default: tmr_load_val = TW'(DOOR_TIMEOUT - 1);
        endcase
    end

    always_comb begin
        if (!reset) begin
            assert (!(state == FILL && int'(tmr_value) >= FILL_CYCLES));
            assert (!(state == DRAIN && int'(tmr_value) >= DRAIN_CYCLES));
        end
    end

    always_comb begin
        inner_door_open = 1'b0;
        outer_door_open = 1'b0;
        pump_fill       = 1'b0;
        pump_drain      = 1'b0;
        busy            = 1'b1;
        chamber_wet     = 1'b0;
        case (state)
            DRY_IDLE:   busy = 1'b0;
            WET_IDLE: begin
                busy        = 1'b0;
                chamber_wet = 1'b1;
            end
            FILL:       pump_fill = 1'b1;
            DRAIN: begin
                pump_drain  = 1'b1;
                chamber_wet = 1'b1;
            end
            INNER_OPEN: inner_door_open = 1'b1;
            OUTER_OPEN: begin
                outer_door_open = 1'b1;
                chamber_wet     = 1'b1;
            end
            default:    busy = 1'b0;
        endcase
    end

endmodule
